// File: rtl/prescaled_counter.sv
// prescaled_counter: free-running display counter with a programmable
// prescaler. The prescaler divides the clock down to a step rate of
// (div + 1) enabled cycles, and a WIDTH-bit counter advances once per step.
// The counter supports up/down counting, parallel load, a clock enable and
// either wrap-around or saturating behaviour at its boundaries.
module prescaled_counter #(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 26,
  parameter int SATURATE       = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      up,
  input  logic [PRESCALE_WIDTH-1:0] div,
  input  logic                      load,
  input  logic [WIDTH-1:0]          load_value,
  output logic [WIDTH-1:0]          count,
  output logic                      tick,
  output logic                      wrap
);

  localparam logic [WIDTH-1:0]          CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]          CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]          CNT_ONE  = WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] PRE_ZERO = {PRESCALE_WIDTH{1'b0}};
  localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE  = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] pre_q,   pre_d;
  logic [WIDTH-1:0]          count_q, count_d;
  logic                      tick_q,  tick_d;
  logic                      wrap_q,  wrap_d;
  logic                      at_boundary_s;

  // Boundary detect for the current direction: top when counting up, zero when down.
  always_comb begin
    at_boundary_s = 1'b0;
    if (up) begin
      at_boundary_s = (count_q == CNT_MAX);
    end else begin
      at_boundary_s = (count_q == CNT_ZERO);
    end
  end

  // Next-state logic: load beats enable, enable beats hold; pulses default low.
  always_comb begin
    pre_d   = pre_q;
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (load) begin
      // A load restarts the prescale period so the next step is a full period away.
      count_d = load_value;
      pre_d   = PRE_ZERO;
    end else if (enable) begin
      // >= rather than == so that lowering div below pre cannot let pre run away.
      if (pre_q >= div) begin
        pre_d  = PRE_ZERO;
        tick_d = 1'b1;
        if (at_boundary_s) begin
          wrap_d = 1'b1;
          if (SATURATE != 0) begin
            count_d = count_q;
          end else if (up) begin
            count_d = CNT_ZERO;
          end else begin
            count_d = CNT_MAX;
          end
        end else if (up) begin
          count_d = count_q + CNT_ONE;
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end else begin
        pre_d = pre_q + PRE_ONE;
      end
    end else begin
      // Paused: prescaler and count keep their values so the period resumes later.
      pre_d   = pre_q;
      count_d = count_q;
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q   <= PRE_ZERO;
      count_q <= CNT_ZERO;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// Directed bench for prescaled_counter: one wrapping and one saturating
// instance share the same stimulus; expected values are hand-computed.
module tb_prescaled_counter;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        up;
  logic [25:0] div;
  logic        load;
  logic [7:0]  load_value;
  logic [7:0]  count_w, count_s;
  logic        tick_w,  tick_s;
  logic        wrap_w,  wrap_s;

  int checks;
  int errors;

  prescaled_counter #(.WIDTH(8), .PRESCALE_WIDTH(26), .SATURATE(0)) dut_wrap (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .div(div),
    .load(load), .load_value(load_value),
    .count(count_w), .tick(tick_w), .wrap(wrap_w)
  );

  prescaled_counter #(.WIDTH(8), .PRESCALE_WIDTH(26), .SATURATE(1)) dut_sat (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .div(div),
    .load(load), .load_value(load_value),
    .count(count_s), .tick(tick_s), .wrap(wrap_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check all three outputs of the wrapping instance.
  task automatic check_w(input string tag, input logic [7:0] c, input logic t, input logic w);
    check({tag, ".count"}, 32'(count_w), 32'(c));
    check({tag, ".tick"},  32'(tick_w),  32'(t));
    check({tag, ".wrap"},  32'(wrap_w),  32'(w));
  endtask

  // Check all three outputs of the saturating instance.
  task automatic check_s(input string tag, input logic [7:0] c, input logic t, input logic w);
    check({tag, ".count"}, 32'(count_s), 32'(c));
    check({tag, ".tick"},  32'(tick_s),  32'(t));
    check({tag, ".wrap"},  32'(wrap_s),  32'(w));
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    enable     = 1'b1;
    up         = 1'b1;
    div        = 26'd3;
    load       = 1'b0;
    load_value = 8'h00;

    // Reset held for two edges with enable high.
    for (int i = 0; i < 2; i++) begin
      step();
      check_w("reset_w", 8'h00, 1'b0, 1'b0);
      check_s("reset_s", 8'h00, 1'b0, 1'b0);
    end

    // Basic rate: div=3 -> tick on edges 4, 8, ...; count 10 at edge 40.
    reset = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      check_w("rate", 8'(k / 4), ((k % 4) == 0), 1'b0);
    end
    check("rate_final", 32'(count_w), 32'd10);

    // Wrap-around up from FE with div=0 (saturating instance in parallel).
    div        = 26'd0;
    load       = 1'b1;
    load_value = 8'hFE;
    step();
    check_w("ld_fe_w", 8'hFE, 1'b0, 1'b0);
    check_s("ld_fe_s", 8'hFE, 1'b0, 1'b0);
    load = 1'b0;
    step();
    check_w("up1_w", 8'hFF, 1'b1, 1'b0);
    check_s("up1_s", 8'hFF, 1'b1, 1'b0);
    step();
    check_w("up2_w", 8'h00, 1'b1, 1'b1);
    check_s("up2_s", 8'hFF, 1'b1, 1'b1);
    step();
    check_w("up3_w", 8'h01, 1'b1, 1'b0);
    check_s("up3_s", 8'hFF, 1'b1, 1'b1);

    // Wrap-around down from 01.
    up         = 1'b0;
    load       = 1'b1;
    load_value = 8'h01;
    step();
    check_w("ld_01_w", 8'h01, 1'b0, 1'b0);
    load = 1'b0;
    step();
    check_w("dn1_w", 8'h00, 1'b1, 1'b0);
    check_s("dn1_s", 8'h00, 1'b1, 1'b0);
    step();
    check_w("dn2_w", 8'hFF, 1'b1, 1'b1);
    check_s("dn2_s", 8'h00, 1'b1, 1'b1);

    // Saturate down at zero: wrap pulses every step attempt.
    load       = 1'b1;
    load_value = 8'h00;
    step();
    check_s("ld_00_s", 8'h00, 1'b0, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_s("sat_dn", 8'h00, 1'b1, 1'b1);
    end

    // Enable pause: div=9, 5 enabled, 7 paused, then step after 5 more.
    up         = 1'b1;
    div        = 26'd9;
    load       = 1'b1;
    load_value = 8'h00;
    step();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_w("pause_pre", 8'h00, 1'b0, 1'b0);
    end
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check_w("pause_hold", 8'h00, 1'b0, 1'b0);
    end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_w("pause_resume", 8'h00, 1'b0, 1'b0);
    end
    step();
    check_w("pause_step", 8'h01, 1'b1, 1'b0);

    // div lowered below pre: pre=6, div=2 -> step on the next edge.
    for (int i = 0; i < 6; i++) begin
      step();
      check_w("div_pre", 8'h01, 1'b0, 1'b0);
    end
    div = 26'd2;
    step();
    check_w("div_drop", 8'h02, 1'b1, 1'b0);

    // Load collides with a due step: load wins, period restarts.
    div = 26'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      check_w("coll_pre", 8'h02, 1'b0, 1'b0);
    end
    load       = 1'b1;
    load_value = 8'h55;
    step();
    check_w("coll_load", 8'h55, 1'b0, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_w("coll_wait", 8'h55, 1'b0, 1'b0);
    end
    step();
    check_w("coll_step", 8'h56, 1'b1, 1'b0);

    // Reset beats load.
    reset      = 1'b1;
    load       = 1'b1;
    load_value = 8'hAA;
    step();
    check_w("rst_load_w", 8'h00, 1'b0, 1'b0);
    check_s("rst_load_s", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    load  = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prescaled_counter.md
# prescaled_counter

Parametrised free-running display counter. A programmable prescaler divides `clock` down to a step rate, and a WIDTH-bit counter advances once per step. The counter supports up/down direction, parallel load, clock enable, and a wrap or saturate mode. It drives board LEDs and general timebases, and is the generalised next generation of the fixed 8-bit / 2^26 LED counter.

## Interface
Parameters:
- `WIDTH`, default 8: counter width in bits, legal range 1 to 32.
- `PRESCALE_WIDTH`, default 26: prescaler and divisor width in bits, legal range 1 to 32.
- `SATURATE`, default 0: 0 selects wrap-around; 1 selects clamp at the boundaries.

Ports:
- `clock`, in, 1: single clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-high; sampled only on the rising edge of `clock`.
- `enable`, in, 1: 1 lets the prescaler and counter run; 0 freezes both.
- `up`, in, 1: 1 counts up, 0 counts down; sampled on step cycles.
- `div`, in, PRESCALE_WIDTH: step period minus one, in `clock` cycles.
- `load`, in, 1: parallel-load request.
- `load_value`, in, WIDTH: value written to `count` on load.
- `count`, out, WIDTH: registered counter value.
- `tick`, out, 1: registered one-cycle pulse on every counter step.
- `wrap`, out, 1: registered one-cycle pulse on a boundary event (see Operation).

## Operation
- Internal state: `pre`, PRESCALE_WIDTH bits. Outputs `count`, `tick` and `wrap` are all registered.
- Priority on each edge is `reset` > `load` > `enable` > hold.
- Reset, on any edge with `reset`=1:
  - `pre`=0, `count`=0, `tick`=0, `wrap`=0.
  - All other inputs are ignored in that cycle.
  - Reset asserted in the middle of a prescale period discards the partial period.
- Load, with `reset`=0 and `load`=1:
  - `count`=`load_value`, `pre`=0, `tick`=0, `wrap`=0.
  - Load ignores `enable`.
- Run, with `enable`=1 and no reset or load:
  - If `pre` >= `div`, this is a step cycle: `pre`=0, `tick`=1, and `count` updates as described below.
  - Otherwise, `pre`=`pre`+1 and `tick`=0.
  - The compare is >=, so lowering `div` below the current `pre` forces a step on the next enabled edge. `pre` never runs away past `div`.
- Hold, with `enable`=0:
  - `pre` and `count` keep their values.
  - `tick`=0 and `wrap`=0.
- Count update on a step cycle:
  - Up, `count` below 2^WIDTH-1: `count`+1, `wrap`=0.
  - Up, `count` = 2^WIDTH-1: if SATURATE=0, `count`=0; if SATURATE=1, `count` stays. `wrap`=1 in both cases.
  - Down, `count` above 0: `count`-1, `wrap`=0.
  - Down, `count` = 0: if SATURATE=0, `count`=2^WIDTH-1; if SATURATE=1, `count` stays at 0. `wrap`=1 in both cases.
  - Arithmetic is modulo 2^WIDTH with no overflow into other state.
- `wrap` is only ever high together with `tick`.
- In SATURATE=1 mode, `wrap` repeats on every step attempted at the boundary.

## Timing
- The step period is `div`+1 enabled cycles.
  - `div`=0 steps on every enabled cycle.
  - The maximum period is 2^PRESCALE_WIDTH cycles, which matches the legacy rate at the default parameters.
- From reset or load release with `enable`=1 held high, the first step edge is edge number `div`+1.
- `count` and `tick` change on the same edge. The new `count` value is visible while `tick`=1.
- `up` and `div` are sampled in the cycle in which they are used. Changing them mid-period takes effect at the next compare, with no resynchronisation.
- Deasserting `enable` pauses the period. Reasserting it resumes from the stored `pre` value, so the total enabled cycles per step stays `div`+1.
- Load and `enable`=1 in the same cycle: load wins and the prescale period restarts.

## Test plan
- Reset: drive `reset`=1 with `enable`=1, `div`=3, `load`=0 for 2 edges -> `count`=0, `tick`=0 and `wrap`=0 on every edge.
- Basic rate, WIDTH=8, SATURATE=0, `div`=3, `up`=1, `enable`=1, run 40 cycles from reset:
  - `tick` on edges 4, 8, 12, …
  - `count` reaches 10 at edge 40.
  - No `wrap`.
- Wrap-around:
  - Up: load 8'hFE, `div`=0, `up`=1 -> `count` sequence FF, 00, 01, with `wrap`=1 only on the FF->00 edge.
  - Down: load 8'h01, `up`=0 -> `count` sequence 00, FF, with `wrap` only on 00->FF.
- Saturate, SATURATE=1:
  - Up: load 8'hFE, `div`=0, `up`=1 -> `count` sequence FF, FF, FF, with `wrap`=1 on the 2nd and 3rd steps.
  - Down: load 0 with `up`=0 -> `count` stays 0 and `wrap` pulses every cycle.
- Enable pause and `div` change:
  - `div`=9, drop `enable` after 5 enabled cycles, hold it low for 7 cycles, then reassert -> `tick` after 5 more enabled cycles.
  - With `pre`=6, write `div`=2 -> `tick` on the next edge.
- Simultaneous events:
  - `load`=1 with `load_value`=8'h55 and `enable`=1, on the same edge a step would occur -> `count`=55, `tick`=0, and the next step occurs `div`+1 cycles later.
  - `reset`=1 and `load`=1 together -> `count`=0.
